// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between two
// byte requesters. A granted byte is held on tx_data with tx_en_sig high until
// the transmitter pulses tx_done (or the watchdog expires). The owner then gets
// a one-cycle acknowledge. A single GAP cycle follows so the transmitter sees
// tx_en_sig low and re-arms before the next frame.
module uart_tx_arbiter #(
   parameter logic [15:0] TIMEOUT = 16'd4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       tx_en_sig,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic       busy,
   output logic       err_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [15:0] WDOG_MAX = 16'hFFFF;

   state_t      state_reg, state_next;

   logic        tx_en_reg, tx_en_next;
   logic [7:0]  tx_data_reg, tx_data_next;
   logic        owner_reg, owner_next;
   logic        last_reg, last_next;
   logic [15:0] wdog_reg, wdog_next;
   logic [1:0]  ack_reg, ack_next;
   logic        ack_fire;
   logic        err_reg, err_next;
   logic        busy_reg, busy_next;

   // Arbitration and watchdog decode
   logic        grant_valid;
   logic        grant_idx;
   logic        timeout_hit;

   // Pick the requester to grant: a lone request wins, a tie goes to the
   // index that was not granted last.
   always_comb begin
      grant_valid = req0 | req1;
      grant_idx   = 1'b0;
      if (req0 && req1) begin
         grant_idx = ~last_reg;
      end else if (req1) begin
         grant_idx = 1'b1;
      end
   end

   // Watchdog expiry: the counter reads k in the k-th cycle after the enable
   // rose, so matching TIMEOUT-1 lands the abort exactly TIMEOUT cycles later.
   assign timeout_hit = (wdog_reg == (TIMEOUT - 16'd1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (grant_valid) begin
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_done || timeout_hit) begin
               state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Output and datapath next values; all of them are registered below so no
   // output depends combinationally on an input.
   always_comb begin
      tx_en_next   = tx_en_reg;
      tx_data_next = tx_data_reg;
      owner_next   = owner_reg;
      last_next    = last_reg;
      wdog_next    = wdog_reg;
      ack_fire     = 1'b0;
      err_next     = 1'b0;
      busy_next    = (state_next != ST_IDLE);
      case (state_reg)
         ST_IDLE: begin
            if (grant_valid) begin
               tx_data_next = grant_idx ? data1 : data0;
               tx_en_next   = 1'b1;
               owner_next   = grant_idx;
               last_next    = grant_idx;
               wdog_next    = 16'd0;
            end
         end
         ST_SEND: begin
            if (wdog_reg != WDOG_MAX) begin
               wdog_next = wdog_reg + 16'd1;
            end
            // A completion in the expiry cycle counts as a normal finish.
            if (tx_done) begin
               tx_en_next = 1'b0;
               ack_fire   = 1'b1;
            end else if (timeout_hit) begin
               tx_en_next = 1'b0;
               ack_fire   = 1'b1;
               err_next   = 1'b1;
            end
         end
         ST_GAP: begin
            tx_en_next = 1'b0;
         end
         default: begin
            tx_en_next = 1'b0;
         end
      endcase
   end

   // Steer the acknowledge pulse to whichever requester owns the frame.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ack
         assign ack_next[gi] = ack_fire && (owner_reg == 1'(gi));
      end
   endgenerate

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_en_reg   <= 1'b0;
         tx_data_reg <= 8'h00;
         owner_reg   <= 1'b0;
         last_reg    <= 1'b1;
         wdog_reg    <= 16'd0;
         ack_reg     <= 2'b00;
         err_reg     <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         tx_en_reg   <= tx_en_next;
         tx_data_reg <= tx_data_next;
         owner_reg   <= owner_next;
         last_reg    <= last_next;
         wdog_reg    <= wdog_next;
         ack_reg     <= ack_next;
         err_reg     <= err_next;
         busy_reg    <= busy_next;
      end
   end

   assign tx_en_sig   = tx_en_reg;
   assign tx_data     = tx_data_reg;
   assign ack0        = ack_reg[0];
   assign ack1        = ack_reg[1];
   assign err_timeout = err_reg;
   assign busy        = busy_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by randomized frames,
// each checked against a round-robin / cycle-count model of the arbiter.
module tb_uart_tx_arbiter;

   localparam logic [15:0] TO = 16'd64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [7:0] data0 = 8'h00;
   logic [7:0] data1 = 8'h00;
   logic       tx_done = 1'b0;
   logic       ack0, ack1, tx_en_sig, busy, err_timeout;
   logic [7:0] tx_data;

   int pass_count  = 0;
   int total_count = 0;
   int fail_count  = 0;
   int frame_no    = 0;
   int model_last  = 1;

   uart_tx_arbiter #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .data0      (data0),
      .ack0       (ack0),
      .req1       (req1),
      .data1      (data1),
      .ack1       (ack1),
      .tx_en_sig  (tx_en_sig),
      .tx_data    (tx_data),
      .tx_done    (tx_done),
      .busy       (busy),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs set and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_count++;
      assert (obs === exp) pass_count++;
      else begin
         fail_count++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_en"}, tx_en_sig, 0);
      check({tag, "_tx_data"}, tx_data, 8'h00);
      check({tag, "_ack0"}, ack0, 0);
      check({tag, "_ack1"}, ack1, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"}, err_timeout, 0);
   endtask

   // One complete frame starting from an IDLE cycle. The transmitter's done
   // pulse comes dly cycles after the enable rises; with do_done=0 it never
   // comes and the watchdog must abort TO cycles after the enable rose.
   task automatic frame(input bit r0, input bit r1, input logic [7:0] d0,
                        input logic [7:0] d1, input int dly, input bit do_done);
      int         owner;
      logic [7:0] exp_data;
      bit         exp_err;
      req0  = r0;
      req1  = r1;
      data0 = d0;
      data1 = d1;
      if (r0 && r1) owner = (model_last == 0) ? 1 : 0;
      else          owner = r0 ? 0 : 1;
      model_last = owner;
      exp_data   = (owner == 1) ? d1 : d0;
      exp_err    = !do_done;

      tick();
      check("grant_en", tx_en_sig, 1);
      check("grant_data", tx_data, exp_data);
      check("grant_busy", busy, 1);
      check("grant_acks", {ack1, ack0}, 2'b00);

      if (do_done) repeat (dly) tick();
      else         repeat (int'(TO) - 1) tick();
      check("send_en", tx_en_sig, 1);
      check("send_data", tx_data, exp_data);
      check("send_acks", {ack1, ack0}, 2'b00);
      check("send_err", err_timeout, 0);

      if (do_done) tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("end_ack0", ack0, (owner == 0));
      check("end_ack1", ack1, (owner == 1));
      check("end_err", err_timeout, exp_err);
      check("end_en", tx_en_sig, 0);
      check("end_busy", busy, 1);
      if (owner == 0) req0 = 1'b0;
      else            req1 = 1'b0;

      tick();
      check("idle_acks", {ack1, ack0}, 2'b00);
      check("idle_err", err_timeout, 0);
      check("idle_en", tx_en_sig, 0);
      check("idle_busy", busy, 0);

      frame_no++;
      $display("frame %0d: req=%0b%0b owner=%0d data=%02h done_dly=%0d timeout=%0b",
               frame_no, r1, r0, owner, exp_data, do_done ? dly : int'(TO), exp_err);
   endtask

   initial begin
      int pattern;

      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();
      check("post_reset_busy", busy, 0);
      check("post_reset_en", tx_en_sig, 0);

      // Contention from reset: expect 0,1,0,1
      for (int i = 0; i < 4; i++) begin
         frame(1'b1, 1'b1, 8'h11, 8'h22, int'($urandom_range(0, 20)), 1'b1);
      end

      // Single request
      frame(1'b1, 1'b0, 8'hA5, 8'h00, 40, 1'b1);

      // Spurious done while idle
      req0 = 1'b0;
      req1 = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("spur_acks", {ack1, ack0}, 2'b00);
      check("spur_err", err_timeout, 0);
      check("spur_busy", busy, 0);
      check("spur_en", tx_en_sig, 0);
      tick();
      check("spur_busy2", busy, 0);
      $display("spurious tx_done in idle ignored");

      // Back-to-back requester 1
      for (int i = 0; i < 4; i++) begin
         frame(1'b0, 1'b1, 8'h00, 8'(8'h30 + i), int'($urandom_range(0, 10)), 1'b1);
      end

      // Watchdog abort, then done coinciding with expiry
      frame(1'b1, 1'b0, 8'h5A, 8'h00, 0, 1'b0);
      frame(1'b1, 1'b0, 8'h6B, 8'h00, int'(TO) - 1, 1'b1);

      // Reset mid-frame (requester 0 owns it, so last=0 before reset)
      req0  = 1'b1;
      req1  = 1'b0;
      data0 = 8'h3C;
      tick();
      check("rst_mid_en", tx_en_sig, 1);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      check_reset_outputs("rst_mid");
      rst_n = 1'b1;
      req0  = 1'b0;
      model_last = 1;
      tick();
      check("rst_mid_acks", {ack1, ack0}, 2'b00);
      check("rst_mid_busy", busy, 0);
      $display("reset mid-frame: outputs cleared");
      frame(1'b1, 1'b1, 8'hC3, 8'h7E, 5, 1'b1);

      // Randomized frames
      for (int i = 0; i < 24; i++) begin
         pattern = int'($urandom_range(1, 3));
         frame(pattern[0], pattern[1], 8'($urandom), 8'($urandom),
               int'($urandom_range(0, int'(TO) - 1)), ($urandom_range(0, 7) != 0));
      end

      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter (`tx_module`) between two byte requesters. It sits between client logic and the transmitter's `tx_en_sig`/`tx_data`/`tx_done` port. It grants one requester at a time, holds the enable and data stable for the whole frame, and returns a one-cycle acknowledge. A watchdog recovers the block if the transmitter never reports completion.

## Interface
- `TIMEOUT`, default 16'd4096: max cycles in SEND without `tx_done` before abort. Must be greater than one frame; 1040 cycles at 12 MHz / 115200.
- `clk`  in  1: system clock; all logic on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req0`  in  1: requester 0 has a byte; level, held until `ack0`.
- `data0`  in  8: requester 0 byte; stable while `req0` high.
- `ack0`  out  1: one-cycle pulse, requester 0 byte finished (sent or aborted).
- `req1`, `data1`, `ack1`: same as above, for requester 1.
- `tx_en_sig`  out  1: transmitter enable; high for the whole granted frame.
- `tx_data`  out  8: byte to the transmitter; registered, stable while `tx_en_sig` is high.
- `tx_done`  in  1: transmitter one-cycle completion pulse.
- `busy`  out  1: high in SEND and GAP.
- `err_timeout`  out  1: one-cycle pulse when a frame is aborted by the watchdog.

## Operation
- States: IDLE, SEND, GAP. Reset state is IDLE.
- Reset values:
  - `tx_en_sig`=0, `tx_data`=8'h00, `ack0`=`ack1`=0, `busy`=0, `err_timeout`=0.
  - Watchdog counter=0. `last` (last-granted index)=1, so requester 0 wins the first contest.
- IDLE:
  - Exactly one request high: grant it.
  - Both high: grant the index != `last`.
  - On grant: capture the data into `tx_data`, set `tx_en_sig`=1, record the owner, update `last`, clear the counter, go to SEND.
  - No request: stay in IDLE.
- SEND:
  - Counter increments each cycle; 16-bit, saturating.
  - `tx_done`=1: `tx_en_sig`<=0, `ack[owner]`<=1, go to GAP.
  - Else, counter == TIMEOUT-1: `tx_en_sig`<=0, `ack[owner]`<=1, `err_timeout`<=1, go to GAP.
  - `tx_done` and the timeout in the same cycle: treated as done, no error.
- GAP: exactly one cycle with `tx_en_sig`=0 so the transmitter re-arms. Ack/err pulses are cleared. Go to IDLE.
- `tx_done` outside SEND is ignored.
- Request changes during SEND or GAP are ignored. `dataN` is sampled only at grant.
- The requester must drop `reqN` on the edge that samples `ackN`=1. A `reqN` still high in the following IDLE cycle is taken as a new request.
- Reset asserted mid-frame: all state and outputs return to reset values on that edge. No ack is issued for the aborted byte.

## Timing
- Grant latency: `reqN` high in IDLE cycle t gives `tx_en_sig`=1 and valid `tx_data` from cycle t+1.
- Completion: `tx_done` in cycle t gives `ackN`=1 and `tx_en_sig`=0 in t+1, GAP in t+1, IDLE in t+2.
- Earliest next grant is sampled in t+2, with `tx_en_sig` high again in t+3. The minimum enable-low gap is 2 cycles.
- Timeout: if `tx_en_sig` rises in cycle s with no `tx_done`, abort is seen in cycle s+TIMEOUT, with `ackN` and `err_timeout` high together.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- Single request: `req0`=1, `data0`=8'hA5, model `tx_done` 1040 cycles after `tx_en_sig` rises. Expect `tx_data`=8'hA5 from t+1, one `ack0` pulse the cycle after `tx_done`, `err_timeout`=0, `busy` low 2 cycles after `tx_done`.
- Contention: `req0`(8'h11) and `req1`(8'h22) both high from reset.
  - Expect grant order 0,1,0,1 across four frames, re-asserting each request after its ack.
  - Each grant's `tx_data` matches the owner's data.
- Back-to-back same requester: `req1` re-raised immediately after each `ack1`, `req0` idle. Expect continuous grants to 1, with `tx_en_sig` low for exactly 2 cycles between frames.
- Timeout: TIMEOUT=16'd64, `tx_done` held 0.
  - Expect `ack0` and `err_timeout` pulses 64 cycles after `tx_en_sig` rises, then return to IDLE.
  - A `tx_done` in exactly that cycle gives no `err_timeout`.
- Spurious done: `tx_done` pulsed while in IDLE. Expect no ack, no state change.
- Reset mid-frame: `rst_n`=0 for one cycle during SEND. Expect all outputs at reset values on the next edge, no ack, and requester 0 favoured on the next contention.
